// File: rtl/mem_access_unit.sv
// Load/store unit between the pipeline and the data cache: validates alignment,
// drives one cache access per request, formats load data and returns a tagged response.
module mem_access_unit #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    // pipeline request
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic                  req_wrn,
    input  logic [4:0]            req_rd,
    input  logic                  flush,
    // pipeline response
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_misaligned,
    // data cache
    output logic [ADDR_WIDTH-1:0] dc_addr,
    output logic [DATA_WIDTH-1:0] dc_wdata,
    output logic [1:0]            dc_wlen,
    output logic                  dc_enable,
    output logic                  dc_wrn,
    input  logic [DATA_WIDTH-1:0] dc_rdata,
    input  logic                  dc_valid,
    input  logic                  dc_write_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t                state_q;
    logic                  kill_q;
    logic [ADDR_WIDTH-1:0] lat_addr_q;
    logic [DATA_WIDTH-1:0] lat_wdata_q;
    logic [1:0]            lat_size_q;
    logic                  lat_unsigned_q;
    logic                  lat_wrn_q;
    logic                  dc_enable_q;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [4:0]            resp_rd_q;
    logic                  resp_misaligned_q;

    logic                  accept;
    logic                  req_misaligned;
    logic                  complete;
    logic [5:0]            shift_amt;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] load_data;

    always_comb begin
        req_ready = (state_q == ST_IDLE) ||
                    ((state_q == ST_RESP) && resp_ready && !flush);
        accept    = req_valid && req_ready;

        unique case (req_size)
            2'd0:    req_misaligned = 1'b0;
            2'd1:    req_misaligned = req_addr[0];
            2'd2:    req_misaligned = (req_addr[1:0] != 2'b00);
            default: req_misaligned = (req_addr[2:0] != 3'b000);
        endcase

        complete = (state_q == ST_ACCESS) && (lat_wrn_q ? dc_write_done : dc_valid);
    end

    // The cache returns the whole aligned word; pick the addressed lane and extend it.
    always_comb begin
        shift_amt = {lat_addr_q[2:0], 3'b000};
        shifted   = dc_rdata >> shift_amt;
        unique case (lat_size_q)
            2'd0: load_data = {{(DATA_WIDTH-8){~lat_unsigned_q & shifted[7]}},   shifted[7:0]};
            2'd1: load_data = {{(DATA_WIDTH-16){~lat_unsigned_q & shifted[15]}}, shifted[15:0]};
            2'd2: load_data = {{(DATA_WIDTH-32){~lat_unsigned_q & shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            kill_q            <= 1'b0;
            lat_addr_q        <= '0;
            lat_wdata_q       <= '0;
            lat_size_q        <= 2'd0;
            lat_unsigned_q    <= 1'b0;
            lat_wrn_q         <= 1'b0;
            dc_enable_q       <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_data_q       <= '0;
            resp_rd_q         <= 5'd0;
            resp_misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    kill_q <= 1'b0;
                end
                ST_ACCESS: begin
                    if (flush) begin
                        kill_q <= 1'b1;
                    end
                    if (complete) begin
                        // Drop enable on the completion edge so the cache never repeats the access.
                        dc_enable_q <= 1'b0;
                        if (kill_q || flush) begin
                            state_q <= ST_IDLE;
                            kill_q  <= 1'b0;
                        end else begin
                            state_q           <= ST_RESP;
                            resp_valid_q      <= 1'b1;
                            resp_misaligned_q <= 1'b0;
                            resp_data_q       <= lat_wrn_q ? '0 : load_data;
                        end
                    end
                end
                ST_RESP: begin
                    if (flush || resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // A new request overrides the RESP->IDLE transition above (back-to-back).
            if (accept) begin
                lat_addr_q     <= req_addr;
                lat_wdata_q    <= req_wdata;
                lat_size_q     <= req_size;
                lat_unsigned_q <= req_unsigned;
                lat_wrn_q      <= req_wrn;
                resp_rd_q      <= req_rd;
                if (req_misaligned) begin
                    state_q           <= ST_RESP;
                    resp_valid_q      <= 1'b1;
                    resp_misaligned_q <= 1'b1;
                    resp_data_q       <= '0;
                end else begin
                    state_q           <= ST_ACCESS;
                    dc_enable_q       <= 1'b1;
                    resp_valid_q      <= 1'b0;
                    resp_misaligned_q <= 1'b0;
                end
            end
        end
    end

    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign resp_rd         = resp_rd_q;
    assign resp_misaligned = resp_misaligned_q;
    assign dc_addr         = lat_addr_q;
    assign dc_wdata        = lat_wdata_q;
    assign dc_wlen         = lat_size_q;
    assign dc_wrn          = lat_wrn_q;
    assign dc_enable       = dc_enable_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalignment, back-to-back,
// flush in ACCESS/RESP and asynchronous reset during an access.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        req_wrn;
    logic [4:0]  req_rd;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic [63:0] dc_addr;
    logic [63:0] dc_wdata;
    logic [1:0]  dc_wlen;
    logic        dc_enable;
    logic        dc_wrn;
    logic [63:0] dc_rdata;
    logic        dc_valid;
    logic        dc_write_done;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_wrn         (req_wrn),
        .req_rd          (req_rd),
        .flush           (flush),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_misaligned (resp_misaligned),
        .dc_addr         (dc_addr),
        .dc_wdata        (dc_wdata),
        .dc_wlen         (dc_wlen),
        .dc_enable       (dc_enable),
        .dc_wrn          (dc_wrn),
        .dc_rdata        (dc_rdata),
        .dc_valid        (dc_valid),
        .dc_write_done   (dc_write_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [1:0] size, input logic uns,
                             input logic wrn, input logic [4:0] rd);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_wrn      = wrn;
        req_rd       = rd;
    endtask

    // Load held in ACCESS for three cycles, then dc_valid; response consumed one cycle later.
    task automatic run_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                            input logic uns, input logic [63:0] rdata, input logic [4:0] rd,
                            input logic [63:0] exp);
        @(negedge clk);
        check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
        drive_req(addr, 64'd0, size, uns, 1'b0, rd);
        @(negedge clk);
        req_valid = 1'b0;
        check({tag, "_dc_en"}, {63'd0, dc_enable}, 64'd1);
        check({tag, "_dc_addr"}, dc_addr, addr);
        check({tag, "_dc_wrn"}, {63'd0, dc_wrn}, 64'd0);
        check({tag, "_dc_wlen"}, {62'd0, dc_wlen}, {62'd0, size});
        repeat (2) begin
            @(negedge clk);
            check({tag, "_dc_en_hold"}, {63'd0, dc_enable}, 64'd1);
            check({tag, "_no_resp"}, {63'd0, resp_valid}, 64'd0);
        end
        dc_valid = 1'b1;
        dc_rdata = rdata;
        @(negedge clk);
        dc_valid = 1'b0;
        check({tag, "_dc_en_off"}, {63'd0, dc_enable}, 64'd0);
        check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd1);
        check({tag, "_resp_data"}, resp_data, exp);
        check({tag, "_resp_rd"}, {59'd0, resp_rd}, {59'd0, rd});
        check({tag, "_misal"}, {63'd0, resp_misaligned}, 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check({tag, "_resp_done"}, {63'd0, resp_valid}, 64'd0);
        $display("txn %s: load addr=0x%0h size=%0d data=0x%0h rd=%0d", tag, addr, size, resp_data, rd);
    endtask

    initial begin
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_size      = 2'd0;
        req_unsigned  = 1'b0;
        req_wrn       = 1'b0;
        req_rd        = 5'd0;
        flush         = 1'b0;
        resp_ready    = 1'b0;
        dc_rdata      = '0;
        dc_valid      = 1'b0;
        dc_write_done = 1'b0;

        #2;
        check("rst_dc_en", {63'd0, dc_enable}, 64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_dc_addr", dc_addr, 64'd0);
        check("rst_dc_wdata", dc_wdata, 64'd0);
        check("rst_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        reset = 1'b0;
        $display("txn reset: released");

        // Signed byte at lane 5, plus halfword/word variants of the same cache word.
        run_load("ld_sb", 64'h8000_0005, 2'd0, 1'b0, 64'h0000_80AB_0000_0000, 5'd1, 64'hFFFF_FFFF_FFFF_FF80);
        run_load("ld_uh", 64'h8000_0004, 2'd1, 1'b1, 64'h0000_80AB_0000_0000, 5'd2, 64'h0000_0000_0000_80AB);
        run_load("ld_sh", 64'h8000_0004, 2'd1, 1'b0, 64'h0000_80AB_0000_0000, 5'd5, 64'hFFFF_FFFF_FFFF_80AB);
        run_load("ld_sw", 64'h8000_0004, 2'd2, 1'b0, 64'hF000_80AB_0000_0000, 5'd6, 64'hFFFF_FFFF_F000_80AB);

        // Store: data passes through unshifted.
        @(negedge clk);
        drive_req(64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, 1'b0, 1'b1, 5'd9);
        @(negedge clk);
        req_valid = 1'b0;
        check("st_dc_wdata", dc_wdata, 64'h1122_3344_5566_7788);
        check("st_dc_wrn", {63'd0, dc_wrn}, 64'd1);
        check("st_dc_en", {63'd0, dc_enable}, 64'd1);
        check("st_dc_addr", dc_addr, 64'h8000_0010);
        dc_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        dc_valid = 1'b1;
        @(negedge clk);
        dc_valid = 1'b0;
        check("st_wait_en", {63'd0, dc_enable}, 64'd1);
        check("st_wait_resp", {63'd0, resp_valid}, 64'd0);
        dc_write_done = 1'b1;
        @(negedge clk);
        dc_write_done = 1'b0;
        check("st_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("st_resp_data", resp_data, 64'd0);
        check("st_dc_en_off", {63'd0, dc_enable}, 64'd0);
        @(negedge clk);
        check("st_resp_hold", {63'd0, resp_valid}, 64'd1);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("st_resp_done", {63'd0, resp_valid}, 64'd0);
        $display("txn store: addr=0x8000_0010 data=0x1122334455667788 rd=9");

        // Misaligned word: immediate fault response, no cache access.
        drive_req(64'h8000_0002, 64'd0, 2'd2, 1'b0, 1'b0, 5'd4);
        @(negedge clk);
        req_valid = 1'b0;
        check("mis_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("mis_flag", {63'd0, resp_misaligned}, 64'd1);
        check("mis_data", resp_data, 64'd0);
        check("mis_rd", {59'd0, resp_rd}, 64'd4);
        check("mis_dc_en", {63'd0, dc_enable}, 64'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("mis_done", {63'd0, resp_valid}, 64'd0);
        check("mis_dc_en2", {63'd0, dc_enable}, 64'd0);
        $display("txn misaligned: addr=0x8000_0002 size=2 rd=4");

        // Back-to-back: second request accepted in the same cycle the first response drains.
        drive_req(64'h8000_0000, 64'd0, 2'd3, 1'b0, 1'b0, 5'd3);
        @(negedge clk);
        req_valid = 1'b0;
        dc_rdata  = 64'h0123_4567_89AB_CDEF;
        dc_valid  = 1'b1;
        @(negedge clk);
        dc_valid = 1'b0;
        check("b2b_resp1_valid", {63'd0, resp_valid}, 64'd1);
        check("b2b_resp1_rd", {59'd0, resp_rd}, 64'd3);
        check("b2b_resp1_data", resp_data, 64'h0123_4567_89AB_CDEF);
        resp_ready = 1'b1;
        drive_req(64'h8000_0008, 64'd0, 2'd2, 1'b0, 1'b0, 5'd7);
        #1;
        check("b2b_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("b2b_gap_valid", {63'd0, resp_valid}, 64'd0);
        check("b2b_dc_en", {63'd0, dc_enable}, 64'd1);
        check("b2b_dc_addr", dc_addr, 64'h8000_0008);
        dc_rdata = 64'h0000_0000_8000_0000;
        dc_valid = 1'b1;
        @(negedge clk);
        dc_valid = 1'b0;
        check("b2b_resp2_valid", {63'd0, resp_valid}, 64'd1);
        check("b2b_resp2_rd", {59'd0, resp_rd}, 64'd7);
        check("b2b_resp2_data", resp_data, 64'hFFFF_FFFF_8000_0000);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("b2b_done", {63'd0, resp_valid}, 64'd0);
        $display("txn back_to_back: tags 3 then 7");

        // Flush while the load is outstanding: access completes, response is dropped.
        drive_req(64'h8000_0020, 64'd0, 2'd3, 1'b0, 1'b0, 5'd11);
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("fl_dc_en_hold", {63'd0, dc_enable}, 64'd1);
        end
        dc_rdata = 64'h5555_5555_5555_5555;
        dc_valid = 1'b1;
        @(negedge clk);
        dc_valid = 1'b0;
        check("fl_no_resp", {63'd0, resp_valid}, 64'd0);
        check("fl_dc_en_off", {63'd0, dc_enable}, 64'd0);
        check("fl_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check("fl_no_resp2", {63'd0, resp_valid}, 64'd0);
        $display("txn flush_access: load rd=11 discarded");

        // Flush in RESP drops the response and blocks a simultaneous request.
        drive_req(64'h8000_0001, 64'd0, 2'd1, 1'b0, 1'b0, 5'd12);
        @(negedge clk);
        check("flr_resp_valid", {63'd0, resp_valid}, 64'd1);
        drive_req(64'h8000_0000, 64'd0, 2'd3, 1'b0, 1'b0, 5'd13);
        resp_ready = 1'b1;
        flush      = 1'b1;
        #1;
        check("flr_not_ready", {63'd0, req_ready}, 64'd0);
        @(negedge clk);
        flush      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("flr_dropped", {63'd0, resp_valid}, 64'd0);
        check("flr_no_access", {63'd0, dc_enable}, 64'd0);
        check("flr_ready", {63'd0, req_ready}, 64'd1);
        $display("txn flush_resp: response rd=12 dropped");

        // Asynchronous reset mid-ACCESS.
        drive_req(64'h8000_0040, 64'd0, 2'd3, 1'b0, 1'b0, 5'd14);
        @(negedge clk);
        req_valid = 1'b0;
        check("ar_dc_en_before", {63'd0, dc_enable}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_dc_en", {63'd0, dc_enable}, 64'd0);
        check("ar_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("ar_dc_addr", dc_addr, 64'd0);
        #1;
        reset    = 1'b0;
        dc_rdata = 64'h7777_7777_7777_7777;
        dc_valid = 1'b1;
        @(negedge clk);
        dc_valid = 1'b0;
        check("ar_no_resp", {63'd0, resp_valid}, 64'd0);
        check("ar_ready", {63'd0, req_ready}, 64'd1);
        @(negedge clk);
        check("ar_no_resp2", {63'd0, resp_valid}, 64'd0);
        $display("txn async_reset: access rd=14 abandoned");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameters: ADDR_WIDTH, 64, address width; DATA_WIDTH, 64, data width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 req_valid  in  1  pipeline memory request present.
REQ-005 req_ready  out  1  unit accepts request this cycle.
REQ-006 req_addr  in  64  byte address.
REQ-007 req_wdata  in  64  store data, right-aligned.
REQ-008 req_size  in  2  access size; bytes = 2^req_size.
REQ-009 req_unsigned  in  1  load zero-extends (1) or sign-extends (0).
REQ-010 req_wrn  in  1  store = 1, load = 0.
REQ-011 req_rd  in  5  destination register tag, passed through.
REQ-012 flush  in  1  discard in-flight or pending response.
REQ-013 resp_valid  out  1  response present.
REQ-014 resp_ready  in  1  pipeline consumes response.
REQ-015 resp_data  out  64  extended load data; 0 for stores.
REQ-016 resp_rd  out  5  latched req_rd.
REQ-017 resp_misaligned  out  1  request faulted; no memory access made.
REQ-018 dc_addr  out  64  address to data cache.
REQ-019 dc_wdata  out  64  store data to data cache.
REQ-020 dc_wlen  out  2  size to data cache, same encoding as req_size.
REQ-021 dc_enable  out  1  data cache request strobe.
REQ-022 dc_wrn  out  1  data cache write/read select.
REQ-023 dc_rdata  in  64  full aligned 64-bit word from data cache.
REQ-024 dc_valid  in  1  load data valid on dc_rdata.
REQ-025 dc_write_done  in  1  store accepted by data cache.

Function
REQ-026 FSM states: IDLE, ACCESS, RESP; one-hot or binary at implementer's choice.
REQ-027 req_ready = (state==IDLE) | (state==RESP & resp_ready & !flush).
REQ-028 Accept = req_valid & req_ready; latch addr, wdata, size, unsigned, wrn, rd.
REQ-029 Misaligned = (size==1 & addr[0]) | (size==2 & addr[1:0]!=0) | (size==3 & addr[2:0]!=0).
REQ-030 Accept with misaligned -> RESP with resp_misaligned=1, resp_data=0; dc_enable stays 0.
REQ-031 Accept aligned -> ACCESS; dc_enable registered to 1 on the same edge.
REQ-032 In ACCESS, dc_addr/dc_wdata/dc_wlen/dc_wrn are the latched values and are held stable until completion.
REQ-033 dc_wdata = latched req_wdata unshifted; the data cache performs lane placement.
REQ-034 Completion = dc_write_done if wrn, else dc_valid; sampled only while in ACCESS.
REQ-035 At the completion edge, dc_enable clears to 0, so the cache sees enable for no cycle after completion (prevents a repeated IO access).
REQ-036 Load formatting on completion: shift dc_rdata right by 8*addr[2:0]; take 8/16/32/64 bits per size; extend per unsigned; register into resp_data.
REQ-037 Store completion registers resp_data=0, resp_misaligned=0.
REQ-038 Completion -> RESP; resp_valid=1 exactly while in RESP and the response has not been killed.
REQ-039 RESP & resp_ready: next state ACCESS/RESP if a new request is accepted the same cycle, else IDLE; back-to-back adds no bubble.
REQ-040 flush in IDLE: no effect. flush in RESP: drop response, go IDLE, accept nothing that cycle.
REQ-041 flush in ACCESS: the transaction runs to completion with dc_enable held; a kill flag is set, and on completion the next state is IDLE with no resp_valid.
REQ-042 Kill flag clears on entering IDLE.
REQ-043 A flush at the completion edge behaves as flush in ACCESS.

Reset
REQ-044 On reset assertion, asynchronously: state=IDLE, dc_enable=0, resp_valid=0, resp_data=0, resp_rd=0, resp_misaligned=0, kill=0, latched fields=0.
REQ-045 Reset during ACCESS abandons the transaction; no response is ever issued for it.
REQ-046 dc_addr/dc_wdata/dc_wlen/dc_wrn read 0 out of reset.

Verification
REQ-047 Load: addr=0x80000005, size=0, unsigned=0, dc_rdata=0x0000_80AB_0000_0000 after 3 cycles of ACCESS -> resp_data=0xFFFF_FFFF_FFFF_FF80; dc_enable low the cycle after dc_valid.
REQ-048 Store: addr=0x80000010, size=3, wdata=0x1122334455667788 -> dc_wdata equals wdata unshifted, dc_wrn=1; one response with resp_data=0 after dc_write_done.
REQ-049 Misaligned: addr=0x80000002, size=2 -> resp_misaligned=1 on the next cycle; dc_enable never asserts.
REQ-050 Back-to-back: resp_ready=1 and req_valid=1 in RESP -> new ACCESS starts the next cycle; two responses with correct resp_rd tags 3 and 7.
REQ-051 flush in ACCESS: load outstanding, flush pulse, dc_valid 4 cycles later -> no resp_valid; return to IDLE; req_ready=1.
REQ-052 Async reset mid-ACCESS: reset asserted between edges -> dc_enable=0 and resp_valid=0 immediately, before the next clock edge.
